// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing constants for the register-file write-port controller.
package regfile_ctrl_pkg;

   localparam int unsigned REG_AW       = 3;
   localparam int unsigned REG_DW       = 16;
   localparam int unsigned NREGS        = 2 ** REG_AW;
   localparam int unsigned NREQ_DEFAULT = 3;
   // Pointer value after reset, so that requester 0 is searched first.
   localparam int unsigned RR_RESET_PTR = NREQ_DEFAULT - 1;

   // Width of a binary requester index for n requesters.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr+1 and wraps modulo N.
module rr_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] idx;

   // Walk candidates from lowest to highest priority; the last hit is the winner.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = int'(N); k >= 1; k--) begin
         idx = IW'((int'(ptr) + k) % int'(N));
         if (req[idx]) begin
            gnt     = N'(1) << idx;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler: round-robin writeback arbitration, busy scoreboard,
// RAW stall and destination allocation for the 8x16 register file.
module regfile_wb_scheduler
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEFAULT,
   parameter int unsigned DW   = REG_DW,
   parameter int unsigned AW   = REG_AW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_dr,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic                 alloc_valid,
   input  logic [AW-1:0]        alloc_dr,
   output logic                 alloc_ready,
   input  logic [AW-1:0]        src1,
   input  logic [AW-1:0]        src2,
   input  logic                 use_src1,
   input  logic                 use_src2,
   output logic                 stall,
   output logic                 write_en,
   output logic [AW-1:0]        dr,
   output logic [DW-1:0]        Wrdata,
   output logic [(2**AW)-1:0]   busy,
   output logic                 orphan_err
);

   localparam int unsigned NR = 2 ** AW;
   localparam int unsigned IW = idx_width(NREQ);
   localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

   logic [IW-1:0] ptr;
   logic [IW-1:0] gnt_idx;
   logic          accept;
   logic          alloc_fire;
   logic [AW-1:0] win_dr;
   logic [DW-1:0] win_data;
   logic [NR-1:0] busy_next;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (req_ready),
      .gnt_idx (gnt_idx)
   );

   // Winner payload, alloc handshake and RAW stall.
   always_comb begin
      accept      = |req_valid;
      win_dr      = req_dr[int'(gnt_idx)*AW +: AW];
      win_data    = req_data[int'(gnt_idx)*DW +: DW];
      alloc_ready = alloc_valid & ~busy[alloc_dr];
      alloc_fire  = alloc_valid & alloc_ready;
      stall       = (use_src1 & busy[src1]) | (use_src2 & busy[src2]);
   end

   // Scoreboard update: writeback clears, allocation sets.
   always_comb begin
      busy_next = busy;
      if (accept) begin
         busy_next[win_dr] = 1'b0;
      end
      if (alloc_fire) begin
         busy_next[alloc_dr] = 1'b1;
      end
   end

   // Write-port register, RR pointer, scoreboard and sticky orphan flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_en   <= 1'b0;
         dr         <= '0;
         Wrdata     <= '0;
         ptr        <= PTR_RST;
         busy       <= '0;
         orphan_err <= 1'b0;
      end else begin
         busy <= busy_next;
         if (accept) begin
            write_en <= 1'b1;
            dr       <= win_dr;
            Wrdata   <= win_data;
            ptr      <= gnt_idx;
            if (!busy[win_dr]) begin
               orphan_err <= 1'b1;
            end
         end else begin
            write_en <= 1'b0;
         end
      end
   end

endmodule
